dzmmu: RTL and testbench
========================

# dzmmu

Memory-side responder for the dzcpu MCU bus: decodes every CPU address, serves on-chip HRAM, interrupt registers (IF/IE) and the DIV/TIMA/TMA/TAC timer, and forwards all other accesses to an external memory port. Sits between the CPU's `oMCUAddr/oMCUData/oMCUwe` outputs and the cartridge/WRAM/VRAM/IO fabric. Returns read data registered, one cycle after the address.

## Interface
- `HRAM_BASE`, 16'hFF80, first HRAM address (127 bytes, through 16'hFFFE)
- `iClock`  in  1  system clock (4.194304 MHz)
- `iReset`  in  1  reset, asynchronous, active-low
- `iMCUAddr`  in  16  CPU address
- `iMCUData`  in  8  CPU write data
- `iMCUwe`  in  1  CPU write strobe, one cycle per byte
- `oMCUData`  out  8  registered read data to CPU
- `oExtSel`  out  1  access targets external port (combinational decode)
- `oExtAddr`  out  16  pass-through of `iMCUAddr`
- `oExtData`  out  8  pass-through of `iMCUData`
- `oExtWe`  out  1  `iMCUwe & oExtSel`
- `iExtData`  in  8  external combinational read data
- `iIrqReq`  in  5  one-cycle interrupt set pulses: [0] vblank, [1] stat, [2] timer, [3] serial, [4] joypad
- `oIF`  out  5  interrupt flag register
- `oIE`  out  8  interrupt enable register

## Operation
- Decode: FF04–FF07 timer; FF0F IF; FF80–FFFE HRAM; FFFF IE; all else external.
- Write: on a rising edge with `iMCUwe`=1, target register/HRAM byte takes `iMCUData`. External writes are issued only through `oExtWe`.
- Read: each edge, `oMCUData` <= decoded source of current `iMCUAddr`. IF reads `{3'b111, IF}`; TAC reads `{5'b11111, TAC[2:0]}`; DIV reads `cnt[15:8]`.
- Timer: 16-bit free-running `cnt` increments each clock. A write to DIV (any data) clears `cnt` to 0.
- TAC[1:0] selects tap: 00→`cnt[9]`, 01→`cnt[3]`, 10→`cnt[5]`, 11→`cnt[7]`. TIMA increments on a 1→0 transition of `(tap & TAC[2])`, so clearing DIV or TAC[2] while the tap is 1 produces an increment (hardware-accurate glitch).
- TIMA overflow (FF→00): in the same edge, TIMA <= TMA and IF[2] is set. There is no delay cycle.
- Priority, same edge: a CPU write to TIMA beats the increment/reload; a CPU write to TMA during reload makes the reload use the new TMA.
- IF: `IF <= (write ? iMCUData[4:0] : IF) | iIrqReq | timer_ovf`. Set requests beat a simultaneous clearing write.
- HRAM contents are not reset.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives `oMCUData` valid in N+1. A read in the cycle after a write to the same location returns the new value.
- Ext path: `oExtSel/oExtAddr/oExtData/oExtWe` are combinational from CPU inputs with zero latency. `iExtData` is sampled at the same edge as internal sources.
- Reset (async assert, sync deassert by system) clears `oMCUData`=8'h00, `cnt`=0, TIMA=TMA=0, TAC=0, IF=0, IE=0.
- Reset mid-operation: a pending overflow/reload is discarded. The first edge after deassert behaves as from a fresh reset.
- TIMA increments at most once per cycle. With TAC=3'b101, the period is 16 clocks.

## Configuration
- `DZMMU_TIMER_EN` defined: timer implemented as above.
- Not defined: FF04–FF07 read 8'hFF and ignore writes (not forwarded externally). IF[2] is set only by `iIrqReq[2]`. No `cnt` flops.

## Structure
- Shared package/include: address constants (`ADDR_DIV`, `ADDR_TIMA`, `ADDR_TMA`, `ADDR_TAC`, `ADDR_IF`, `ADDR_IE`, HRAM bounds) and interrupt bit indices (`irq_vblank`…`irq_joypad`), alongside the existing CPU definitions.
- Sub-module `dzmmu_timer`: holds `cnt`, TIMA/TMA/TAC, edge detect and reload. Ports: clock/reset, write strobe + 2-bit register index + data, 8-bit read mux out, `oOverflow` pulse. The instance is wrapped by `DZMMU_TIMER_EN`.
- HRAM: 127×8 register array in `dzmmu`.

## Test plan
- HRAM: write 8'hA5 to FF80 and 8'h3C to FFFE, then read both. Expect 8'hA5 and 8'h3C one cycle after each address; reading FF81 after reset must not affect these.
- Timer overflow: TMA=8'hF0, TIMA=8'hFE, TAC=3'b101. After 32 clocks, TIMA=8'hF0 and IF reads 8'hE4. An IF write of 8'h00 on the overflow edge still leaves IF[2]=1.
- DIV: run 512 clocks and expect DIV=8'h02. Write DIV when `cnt[9]`=1 with TAC=3'b100: DIV reads 8'h00 and TIMA increments by 1.
- Write priority: write TIMA=8'h10 on the same edge as a scheduled increment. Expect 8'h10.
- External: read 16'hC000 with `iExtData`=8'h77 → `oExtSel`=1 and `oMCUData`=8'h77 next cycle. A write to FF40 asserts `oExtWe`; a write to FFFF does not.
- Reset: assert `iReset`=0 mid-count with IE=8'h1F. All state clears immediately (asynchronous); `oMCUData`=8'h00 and IE reads 8'h00 after release.

Source files
------------

// File: rtl/dzmmu_pkg.sv
// dzmmu_pkg -- shared definitions for the dzcpu memory-side responder.
//
// Contents:
//   - CPU-visible address constants for the timer, interrupt registers and HRAM
//   - interrupt bit indices inside IF / IE
//   - timer register index and address-decode target enums
//   - decode_addr(): maps a CPU address to the block that serves it
//
// Configuration macro used by the files importing this package: DZMMU_TIMER_EN
package dzmmu_pkg;

  // Timer registers occupy four consecutive bytes; their low two address
  // bits double as the register index inside dzmmu_timer.
  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;
  localparam logic [15:0] ADDR_IF   = 16'hFF0F;
  localparam logic [15:0] ADDR_IE   = 16'hFFFF;

  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] HRAM_LAST  = 16'hFFFE;
  localparam int          HRAM_DEPTH = 127;

  // Interrupt bit positions in IF / IE
  localparam int irq_vblank = 0;
  localparam int irq_stat   = 1;
  localparam int irq_timer  = 2;
  localparam int irq_serial = 3;
  localparam int irq_joypad = 4;

  typedef enum logic [1:0] {
    TREG_DIV  = 2'd0,
    TREG_TIMA = 2'd1,
    TREG_TMA  = 2'd2,
    TREG_TAC  = 2'd3
  } treg_e;

  typedef enum logic [2:0] {
    SEL_EXT   = 3'd0,
    SEL_TIMER = 3'd1,
    SEL_IF    = 3'd2,
    SEL_HRAM  = 3'd3,
    SEL_IE    = 3'd4
  } sel_e;

  // Anything not claimed on-chip goes to the external port.
  function automatic sel_e decode_addr(input logic [15:0] addr);
    sel_e s;
    s = SEL_EXT;
    if (addr >= ADDR_DIV && addr <= ADDR_TAC) begin
      s = SEL_TIMER;
    end else if (addr == ADDR_IF) begin
      s = SEL_IF;
    end else if (addr >= HRAM_BASE && addr <= HRAM_LAST) begin
      s = SEL_HRAM;
    end else if (addr == ADDR_IE) begin
      s = SEL_IE;
    end
    return s;
  endfunction

endpackage

// File: rtl/dzmmu_timer.sv
// dzmmu_timer -- DIV / TIMA / TMA / TAC timer block.
//
// A 16-bit free-running counter (DIV is its upper byte) feeds a selectable
// tap. TIMA counts falling edges of (tap & TAC[2]); on overflow it reloads
// from TMA in the same edge and pulses oOverflow.
//
// Ports:
//   iClock     in   system clock
//   iReset     in   asynchronous active-low reset
//   iWe        in   write strobe, already qualified by the timer address decode
//   iRegIdx    in   2-bit register index: 0 DIV, 1 TIMA, 2 TMA, 3 TAC
//   iData      in   write data
//   oData      out  combinational read value of the indexed register
//   oOverflow  out  high in the cycle whose rising edge reloads TIMA from TMA
//
// Instantiated by dzmmu only when DZMMU_TIMER_EN is defined.
module dzmmu_timer
  import dzmmu_pkg::*;
(
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iWe,
  input  logic [1:0] iRegIdx,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  output logic       oOverflow
);

  logic [15:0] r_cnt;
  logic [7:0]  r_tima;
  logic [7:0]  r_tma;
  logic [2:0]  r_tac;

  logic        w_wr_div;
  logic        w_wr_tima;
  logic        w_wr_tma;
  logic        w_wr_tac;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  w_tma_nxt;
  logic [2:0]  w_tac_nxt;
  logic [7:0]  w_tima_nxt;
  logic        w_inc;
  logic        w_ovf;

  // Gated tap: the bit TIMA counts falling edges of.
  function automatic logic tap_sig(input logic [15:0] cnt, input logic [2:0] tac);
    logic t;
    case (tac[1:0])
      2'b00:   t = cnt[9];
      2'b01:   t = cnt[3];
      2'b10:   t = cnt[5];
      default: t = cnt[7];
    endcase
    return t & tac[2];
  endfunction

  always_comb begin
    w_wr_div   = iWe && (iRegIdx == TREG_DIV);
    w_wr_tima  = iWe && (iRegIdx == TREG_TIMA);
    w_wr_tma   = iWe && (iRegIdx == TREG_TMA);
    w_wr_tac   = iWe && (iRegIdx == TREG_TAC);

    w_cnt_nxt  = w_wr_div ? 16'h0000 : r_cnt + 16'd1;
    w_tac_nxt  = w_wr_tac ? iData[2:0] : r_tac;
    w_tma_nxt  = w_wr_tma ? iData : r_tma;

    // The edge is detected between the current and next register values,
    // so a DIV clear or TAC change that drops a high tap counts as a fall.
    w_inc      = tap_sig(r_cnt, r_tac) & ~tap_sig(w_cnt_nxt, w_tac_nxt);

    // A CPU write to TIMA overrides the increment and any reload with it.
    w_ovf      = w_inc && (r_tima == 8'hFF) && !w_wr_tima;

    w_tima_nxt = r_tima;
    if (w_wr_tima) begin
      w_tima_nxt = iData;
    end else if (w_ovf) begin
      w_tima_nxt = w_tma_nxt;
    end else if (w_inc) begin
      w_tima_nxt = r_tima + 8'd1;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_cnt  <= 16'h0000;
      r_tima <= 8'h00;
      r_tma  <= 8'h00;
      r_tac  <= 3'b000;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tima <= w_tima_nxt;
      r_tma  <= w_tma_nxt;
      r_tac  <= w_tac_nxt;
    end
  end

  always_comb begin
    case (iRegIdx)
      TREG_DIV:  oData = r_cnt[15:8];
      TREG_TIMA: oData = r_tima;
      TREG_TMA:  oData = r_tma;
      default:   oData = {5'b11111, r_tac};
    endcase
  end

  assign oOverflow = w_ovf;

endmodule

// File: rtl/dzmmu.sv
// dzmmu -- memory-side responder for the dzcpu MCU bus.
//
// Decodes every CPU address: FF04-FF07 timer, FF0F IF, FF80-FFFE HRAM,
// FFFF IE, everything else forwarded to the external port. Read data is
// registered: address in cycle N, oMCUData valid in cycle N+1.
//
// Ports:
//   iClock    in   system clock
//   iReset    in   asynchronous active-low reset
//   iMCUAddr  in   CPU address
//   iMCUData  in   CPU write data
//   iMCUwe    in   CPU write strobe (one cycle per byte)
//   oMCUData  out  registered read data
//   oExtSel   out  access targets the external port (combinational)
//   oExtAddr  out  pass-through of iMCUAddr
//   oExtData  out  pass-through of iMCUData
//   oExtWe    out  iMCUwe qualified by oExtSel
//   iExtData  in   external combinational read data
//   iIrqReq   in   one-cycle interrupt set pulses (vblank, stat, timer, serial, joypad)
//   oIF       out  interrupt flag register
//   oIE       out  interrupt enable register
//
// Configuration: define DZMMU_TIMER_EN to build the timer. Without it the
// timer addresses read 8'hFF, swallow writes, and IF[2] is set only by
// iIrqReq[2].
module dzmmu
  import dzmmu_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iMCUAddr,
  input  logic [7:0]  iMCUData,
  input  logic        iMCUwe,
  output logic [7:0]  oMCUData,
  output logic        oExtSel,
  output logic [15:0] oExtAddr,
  output logic [7:0]  oExtData,
  output logic        oExtWe,
  input  logic [7:0]  iExtData,
  input  logic [4:0]  iIrqReq,
  output logic [4:0]  oIF,
  output logic [7:0]  oIE
);

  sel_e       w_sel;
  logic [7:0] w_timer_rd;
  logic       w_timer_ovf;
  logic [6:0] w_hram_idx;
  logic [7:0] w_rd_data;
  logic [4:0] w_if_nxt;

  logic [7:0] r_mcu_data;
  logic [4:0] r_if;
  logic [7:0] r_ie;
  logic [7:0] r_hram [HRAM_DEPTH];

  assign w_sel      = decode_addr(iMCUAddr);
  // FF80..FFFE map straight onto entries 0..126 through the low 7 bits.
  assign w_hram_idx = iMCUAddr[6:0];

  assign oExtSel  = (w_sel == SEL_EXT);
  assign oExtAddr = iMCUAddr;
  assign oExtData = iMCUData;
  assign oExtWe   = iMCUwe & oExtSel;

`ifdef DZMMU_TIMER_EN
  dzmmu_timer u_timer (
    .iClock    (iClock),
    .iReset    (iReset),
    .iWe       (iMCUwe && (w_sel == SEL_TIMER)),
    .iRegIdx   (iMCUAddr[1:0]),
    .iData     (iMCUData),
    .oData     (w_timer_rd),
    .oOverflow (w_timer_ovf)
  );
`else
  assign w_timer_rd  = 8'hFF;
  assign w_timer_ovf = 1'b0;
`endif

  // Set sources are OR-ed after the write so a clearing write cannot
  // drop a request landing on the same edge.
  always_comb begin
    w_if_nxt = (iMCUwe && (w_sel == SEL_IF)) ? iMCUData[4:0] : r_if;
    w_if_nxt = w_if_nxt | iIrqReq;
    w_if_nxt[irq_timer] = w_if_nxt[irq_timer] | w_timer_ovf;
  end

  always_comb begin
    case (w_sel)
      SEL_TIMER: w_rd_data = w_timer_rd;
      SEL_IF:    w_rd_data = {3'b111, r_if};
      SEL_HRAM:  w_rd_data = r_hram[w_hram_idx];
      SEL_IE:    w_rd_data = r_ie;
      default:   w_rd_data = iExtData;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_mcu_data <= 8'h00;
      r_if       <= 5'b00000;
      r_ie       <= 8'h00;
    end else begin
      r_mcu_data <= w_rd_data;
      r_if       <= w_if_nxt;
      if (iMCUwe && (w_sel == SEL_IE)) begin
        r_ie <= iMCUData;
      end
    end
  end

  // HRAM keeps its contents across reset.
  always_ff @(posedge iClock) begin
    if (iMCUwe && (w_sel == SEL_HRAM)) begin
      r_hram[w_hram_idx] <= iMCUData;
    end
  end

  assign oMCUData = r_mcu_data;
  assign oIF      = r_if;
  assign oIE      = r_ie;

endmodule

// File: tb/tb_dzmmu.sv
// tb_dzmmu -- self-checking bench for dzmmu.
//
// Each bus cycle is driven by step(): inputs change just after the falling
// edge, combinational external-port outputs are compared before the rising
// edge, and the registered read data / IF / IE are compared 1 ns after it.
// Expected values come from a byte-level model of the address map and
// timer rules kept in this file.
module tb_dzmmu;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  ext_data = 8'h00;
  logic [4:0]  irq = 5'b00000;

  logic [7:0]  o_mcu_data;
  logic        o_ext_sel;
  logic [15:0] o_ext_addr;
  logic [7:0]  o_ext_data;
  logic        o_ext_we;
  logic [4:0]  o_if;
  logic [7:0]  o_ie;

  dzmmu dut (
    .iClock   (clk),
    .iReset   (rst_n),
    .iMCUAddr (addr),
    .iMCUData (wdata),
    .iMCUwe   (we),
    .oMCUData (o_mcu_data),
    .oExtSel  (o_ext_sel),
    .oExtAddr (o_ext_addr),
    .oExtData (o_ext_data),
    .oExtWe   (o_ext_we),
    .iExtData (ext_data),
    .iIrqReq  (irq),
    .oIF      (o_if),
    .oIE      (o_ie)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  logic        last_ext_we;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_cnt;
  logic [7:0]  m_tima;
  logic [7:0]  m_tma;
  logic [2:0]  m_tac;
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic [7:0]  m_hram [127];

  task automatic mdl_reset();
    m_cnt  = 16'h0000;
    m_tima = 8'h00;
    m_tma  = 8'h00;
    m_tac  = 3'b000;
    m_if   = 5'b00000;
    m_ie   = 8'h00;
  endtask

  // Timer input: the counter bit chosen by TAC[1:0], gated by TAC[2].
  function automatic logic tap_on(input logic [15:0] cnt, input logic [2:0] tac);
    int pos [4];
    pos = '{9, 3, 5, 7};
    return tac[2] && cnt[pos[tac[1:0]]];
  endfunction

  function automatic logic mdl_is_ext(input logic [15:0] a);
    return !((a >= 16'hFF04 && a <= 16'hFF07) || a == 16'hFF0F || a >= 16'hFF80);
  endfunction

  function automatic logic [7:0] mdl_read(input logic [15:0] a, input logic [7:0] ext);
    if (a >= 16'hFF04 && a <= 16'hFF07) begin
`ifdef DZMMU_TIMER_EN
      if (a == 16'hFF04) return m_cnt[15:8];
      if (a == 16'hFF05) return m_tima;
      if (a == 16'hFF06) return m_tma;
      return {5'b11111, m_tac};
`else
      return 8'hFF;
`endif
    end
    if (a == 16'hFF0F) return {3'b111, m_if};
    if (a >= 16'hFF80 && a <= 16'hFFFE) return m_hram[a - 16'hFF80];
    if (a == 16'hFFFF) return m_ie;
    return ext;
  endfunction

  task automatic mdl_edge(input logic [15:0] a, input logic [7:0] d, input logic w,
                          input logic [4:0] irq_in);
    logic ovf;
    ovf = 1'b0;
`ifdef DZMMU_TIMER_EN
    begin
      logic [15:0] cnt_n;
      logic [2:0]  tac_n;
      logic [7:0]  tma_n;
      logic [7:0]  tima_n;
      cnt_n  = (w && a == 16'hFF04) ? 16'h0000 : m_cnt + 16'd1;
      tac_n  = (w && a == 16'hFF07) ? d[2:0] : m_tac;
      tma_n  = (w && a == 16'hFF06) ? d : m_tma;
      tima_n = m_tima;
      if (w && a == 16'hFF05) begin
        tima_n = d;
      end else if (tap_on(m_cnt, m_tac) && !tap_on(cnt_n, tac_n)) begin
        if (m_tima == 8'hFF) begin
          tima_n = tma_n;
          ovf    = 1'b1;
        end else begin
          tima_n = m_tima + 8'd1;
        end
      end
      m_cnt  = cnt_n;
      m_tac  = tac_n;
      m_tma  = tma_n;
      m_tima = tima_n;
    end
`endif
    m_if = ((w && a == 16'hFF0F) ? d[4:0] : m_if) | irq_in | {2'b00, ovf, 2'b00};
    if (w && a == 16'hFFFF) m_ie = d;
    if (w && a >= 16'hFF80 && a <= 16'hFFFE) m_hram[a - 16'hFF80] = d;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w,
                      input logic [4:0] irq_in, input logic [7:0] ext);
    logic exp_sel;
    addr = a; wdata = d; we = w; irq = irq_in; ext_data = ext;
    #1;
    exp_sel = mdl_is_ext(a);
    check("ext_sel", {15'd0, o_ext_sel}, {15'd0, exp_sel});
    check("ext_we", {15'd0, o_ext_we}, {15'd0, w & exp_sel});
    check("ext_addr", o_ext_addr, a);
    check("ext_data", {8'd0, o_ext_data}, {8'd0, d});
    last_ext_we = o_ext_we;
    exp_q.push_back(mdl_read(a, ext));
    mdl_edge(a, d, w, irq_in);
    @(posedge clk);
    #1;
    check("rdata", {8'd0, o_mcu_data}, {8'd0, exp_q.pop_front()});
    check("if", {11'd0, o_if}, {11'd0, m_if});
    check("ie", {8'd0, o_ie}, {8'd0, m_ie});
    we = 1'b0;
    irq = 5'b00000;
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] a);
    step(a, 8'h00, 1'b0, 5'b00000, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(a, d, 1'b1, 5'b00000, 8'h00);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic fall_next_idle();
    return tap_on(m_cnt, m_tac) && !tap_on(m_cnt + 16'd1, m_tac);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra;
    logic        found;
    logic [7:0]  tima0;

    mdl_reset();
    for (int i = 0; i < 127; i++) m_hram[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", {8'd0, o_mcu_data}, 16'h0000);
    check("rst_if", {11'd0, o_if}, 16'h0000);
    check("rst_ie", {8'd0, o_ie}, 16'h0000);
    rst_n = 1'b1;

    // HRAM: fill with known data, then the corner bytes
    for (int i = 0; i < 127; i++) wr(16'hFF80 + 16'(i), 8'($urandom_range(0, 255)));
    wr(16'hFF80, 8'hA5);
    wr(16'hFFFE, 8'h3C);
    idle(16'hFF81);
    idle(16'hFF80);
    check("hram_ff80", {8'd0, o_mcu_data}, 16'h00A5);
    idle(16'hFFFE);
    check("hram_fffe", {8'd0, o_mcu_data}, 16'h003C);

    // External port
    step(16'hC000, 8'h00, 1'b0, 5'b00000, 8'h77);
    check("ext_rd_c000", {8'd0, o_mcu_data}, 16'h0077);
    wr(16'hFF40, 8'h91);
    check("ext_we_ff40", {15'd0, last_ext_we}, 16'h0001);
    wr(16'hFFFF, 8'h00);
    check("ext_we_ffff", {15'd0, last_ext_we}, 16'h0000);

`ifdef DZMMU_TIMER_EN
    // Overflow with reload
    apply_reset();
    wr(16'hFF06, 8'hF0);
    wr(16'hFF05, 8'hFE);
    wr(16'hFF07, 8'h05);
    for (int i = 0; i < 32; i++) idle(16'hFF05);
    idle(16'hFF05);
    check("ovf_tima", {8'd0, o_mcu_data}, 16'h00F0);
    idle(16'hFF0F);
    check("ovf_if", {8'd0, o_mcu_data}, 16'h00E4);

    // Clearing IF write on the overflow edge
    wr(16'hFF05, 8'hFF);
    wr(16'hFF0F, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (fall_next_idle()) begin
        wr(16'hFF0F, 8'h00);
        found = 1'b1;
      end else begin
        idle(16'hFF0F);
      end
    end
    check("ovf_edge_found", {15'd0, found}, 16'h0001);
    check("if_set_beats_clear", {15'd0, o_if[2]}, 16'h0001);

    // DIV after 512 clocks, then DIV write glitch
    apply_reset();
    for (int i = 0; i < 512; i++) idle(16'hFF04);
    idle(16'hFF04);
    check("div_512", {8'd0, o_mcu_data}, 16'h0002);
    wr(16'hFF07, 8'h04);
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      if (m_cnt[9]) found = 1'b1;
      else idle(16'hFF04);
    end
    check("cnt9_found", {15'd0, found}, 16'h0001);
    tima0 = m_tima;
    wr(16'hFF04, 8'($urandom_range(0, 255)));
    idle(16'hFF04);
    check("div_cleared", {8'd0, o_mcu_data}, 16'h0000);
    idle(16'hFF05);
    check("div_glitch_inc", {8'd0, o_mcu_data}, {8'd0, tima0 + 8'd1});

    // TIMA write beats a scheduled increment
    wr(16'hFF07, 8'h05);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (fall_next_idle()) begin
        wr(16'hFF05, 8'h10);
        found = 1'b1;
      end else begin
        idle(16'hFF05);
      end
    end
    check("inc_edge_found", {15'd0, found}, 16'h0001);
    idle(16'hFF05);
    check("tima_wr_prio", {8'd0, o_mcu_data}, 16'h0010);
`else
    wr(16'hFF05, 8'h12);
    check("tmr_wr_not_ext", {15'd0, last_ext_we}, 16'h0000);
    idle(16'hFF05);
    check("tmr_rd_ff", {8'd0, o_mcu_data}, 16'h00FF);
    idle(16'hFF04);
    check("div_rd_ff", {8'd0, o_mcu_data}, 16'h00FF);
`endif

    // Asynchronous reset mid-operation
    wr(16'hFFFF, 8'h1F);
    step(16'hFFFF, 8'h00, 1'b0, 5'b10101, 8'h00);
    for (int i = 0; i < 5; i++) idle(16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ie", {8'd0, o_ie}, 16'h0000);
    check("async_rst_if", {11'd0, o_if}, 16'h0000);
    check("async_rst_rdata", {8'd0, o_mcu_data}, 16'h0000);
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(16'hFFFF);
    check("ie_after_rst", {8'd0, o_mcu_data}, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'($urandom_range(0, 65535));
        1:       ra = 16'hFF00 + 16'($urandom_range(0, 16));
        2:       ra = 16'hFF80 + 16'($urandom_range(0, 127));
        3:       ra = 16'hFF04 + 16'($urandom_range(0, 3));
        default: ra = ($urandom_range(0, 1) == 0) ? 16'hFF0F : 16'hFF05;
      endcase
      // Keep DIV writes rare so the tap gets a chance to run
      if (ra == 16'hFF04 && $urandom_range(0, 7) != 0) ra = 16'hFF05;
      step(ra, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000,
           8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
